// File: rtl/msrv32_csr_pkg.sv
// rtl/msrv32_csr_pkg.sv - shared constants and types for the msrv32 trap/interrupt CSR unit
package msrv32_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [4:0] IRQ_CODE_MSI = 5'd3;
  localparam logic [4:0] IRQ_CODE_MTI = 5'd7;
  localparam logic [4:0] IRQ_CODE_MEI = 5'd11;
  localparam int         LIRQ_BASE    = 16;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } trap_state_t;

endpackage

// File: rtl/msrv32_irq_csr_unit_if.sv
// rtl/msrv32_irq_csr_unit_if.sv - CSR access and trap handshake bundle between pipeline and CSR unit
interface msrv32_irq_csr_unit_if;

  logic        wr_en_in;
  logic [11:0] csr_addr_in;
  logic [2:0]  csr_op_in;
  logic [4:0]  csr_uimm_in;
  logic [31:0] csr_data_in;
  logic [31:0] csr_data_out;
  logic [31:0] pc_in;
  logic        exc_valid_in;
  logic [3:0]  exc_cause_in;
  logic [31:0] exc_tval_in;
  logic        trap_req_out;
  logic        trap_ack_in;
  logic [31:0] trap_address_out;
  logic        mret_in;
  logic [31:0] epc_out;
  logic        mie_out;
  logic        irq_pending_out;

  modport master (
    output wr_en_in, csr_addr_in, csr_op_in, csr_uimm_in, csr_data_in,
    output pc_in, exc_valid_in, exc_cause_in, exc_tval_in, trap_ack_in, mret_in,
    input  csr_data_out, trap_req_out, trap_address_out, epc_out, mie_out, irq_pending_out
  );

  modport slave (
    input  wr_en_in, csr_addr_in, csr_op_in, csr_uimm_in, csr_data_in,
    input  pc_in, exc_valid_in, exc_cause_in, exc_tval_in, trap_ack_in, mret_in,
    output csr_data_out, trap_req_out, trap_address_out, epc_out, mie_out, irq_pending_out
  );

endinterface

// File: rtl/msrv32_irq_arbiter.sv
// rtl/msrv32_irq_arbiter.sv - interrupt synchronisation, edge pending flops, mip vector and priority encoder
module msrv32_irq_arbiter
  import msrv32_csr_pkg::*;
#(
  parameter int                  NUM_LIRQ  = 4,
  parameter logic [NUM_LIRQ-1:0] LIRQ_EDGE = '0
) (
  input  logic                clock,
  input  logic                rst_in,
  input  logic                e_irq,
  input  logic                t_irq,
  input  logic                s_irq,
  input  logic [NUM_LIRQ-1:0] lirq,
  input  logic [NUM_LIRQ-1:0] lirq_clr,
  input  logic [31:0]         mie,
  output logic [31:0]         mip,
  output logic                irq_valid,
  output logic [4:0]          irq_code
);

  logic                e_sync, t_sync, s_sync;
  logic [NUM_LIRQ-1:0] l_sync, l_prev, l_pend;
  logic [31:0]         active;

  // Sync every line once; edge channels latch a rising edge until software clears it (set beats clear)
  always_ff @(posedge clock or negedge rst_in) begin
    if (!rst_in) begin
      e_sync <= 1'b0;
      t_sync <= 1'b0;
      s_sync <= 1'b0;
      l_sync <= '0;
      l_prev <= '0;
      l_pend <= '0;
    end else begin
      e_sync <= e_irq;
      t_sync <= t_irq;
      s_sync <= s_irq;
      l_sync <= lirq;
      l_prev <= l_sync;
      l_pend <= LIRQ_EDGE & ((l_sync & ~l_prev) | (l_pend & ~lirq_clr));
    end
  end

  // Assemble the architectural mip view from synced levels and edge pending bits
  always_comb begin
    mip = '0;
    mip[IRQ_CODE_MEI] = e_sync;
    mip[IRQ_CODE_MTI] = t_sync;
    mip[IRQ_CODE_MSI] = s_sync;
    for (int i = 0; i < NUM_LIRQ; i++) begin
      mip[LIRQ_BASE + i] = LIRQ_EDGE[i] ? l_pend[i] : l_sync[i];
    end
  end

  // Fixed priority: MEI, MSI, MTI, then local lines with the lowest index winning
  always_comb begin
    active    = mip & mie;
    irq_valid = |active;
    irq_code  = '0;
    if (active[IRQ_CODE_MEI]) begin
      irq_code = IRQ_CODE_MEI;
    end else if (active[IRQ_CODE_MSI]) begin
      irq_code = IRQ_CODE_MSI;
    end else if (active[IRQ_CODE_MTI]) begin
      irq_code = IRQ_CODE_MTI;
    end else begin
      for (int i = NUM_LIRQ - 1; i >= 0; i--) begin
        if (active[LIRQ_BASE + i]) irq_code = 5'(LIRQ_BASE + i);
      end
    end
  end

endmodule

// File: rtl/msrv32_irq_csr_unit.sv
// rtl/msrv32_irq_csr_unit.sv - machine-mode trap CSRs, trap request FSM and trap address generation
module msrv32_irq_csr_unit
  import msrv32_csr_pkg::*;
#(
  parameter int                  NUM_LIRQ    = 4,
  parameter logic [NUM_LIRQ-1:0] LIRQ_EDGE   = '0,
  parameter logic [31:0]         RESET_MTVEC = 32'h0000_0000
) (
  input  logic                clock,
  input  logic                rst_in,
  input  logic                e_irq_in,
  input  logic                t_irq_in,
  input  logic                s_irq_in,
  input  logic [NUM_LIRQ-1:0] lirq_in,
  msrv32_irq_csr_unit_if.slave bus
);

  localparam logic [31:0] LIRQ_MASK = ((32'h1 << NUM_LIRQ) - 32'h1) << LIRQ_BASE;
  localparam logic [31:0] MIE_MASK  = 32'h0000_0888 | LIRQ_MASK;

  trap_state_t         state, state_next;
  logic                take_trap, ack_trap, mret_ok;
  logic                st_mie, st_mpie;
  logic [31:0]         mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [5:0]          snap_cause;
  logic [31:0]         snap_epc, snap_tval;
  logic [31:0]         mip, rdata, operand, wdata, base;
  logic                irq_valid;
  logic [4:0]          irq_code;
  logic [NUM_LIRQ-1:0] lirq_clr;

  msrv32_irq_arbiter #(.NUM_LIRQ(NUM_LIRQ), .LIRQ_EDGE(LIRQ_EDGE)) u_arbiter (
    .clock     (clock),
    .rst_in    (rst_in),
    .e_irq     (e_irq_in),
    .t_irq     (t_irq_in),
    .s_irq     (s_irq_in),
    .lirq      (lirq_in),
    .lirq_clr  (lirq_clr),
    .mie       (mie_q),
    .mip       (mip),
    .irq_valid (irq_valid),
    .irq_code  (irq_code)
  );

  // Read mux: pre-write value of the addressed CSR, zero for unimplemented addresses
  always_comb begin
    case (bus.csr_addr_in)
      CSR_MSTATUS:  rdata = {24'b0, st_mpie, 3'b0, st_mie, 3'b0};
      CSR_MIE:      rdata = mie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MTVAL:    rdata = mtval_q;
      CSR_MIP:      rdata = mip;
      default:      rdata = '0;
    endcase
  end

  // Read-modify-write value from the selected operand and operation
  always_comb begin
    operand = bus.csr_op_in[2] ? {27'b0, bus.csr_uimm_in} : bus.csr_data_in;
    case (bus.csr_op_in[1:0])
      CSR_OP_WRITE: wdata = operand;
      CSR_OP_SET:   wdata = rdata | operand;
      CSR_OP_CLEAR: wdata = rdata & ~operand;
      default:      wdata = rdata;
    endcase
  end

  assign lirq_clr = (bus.wr_en_in && bus.csr_addr_in == CSR_MIP) ? ~wdata[LIRQ_BASE +: NUM_LIRQ] : '0;
  assign mret_ok  = bus.mret_in && (state == ST_IDLE);

  // Trap FSM state register
  always_ff @(posedge clock or negedge rst_in) begin
    if (!rst_in) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Trap FSM next state: requests are sticky until the pipeline acknowledges
  always_comb begin
    state_next       = state;
    take_trap        = 1'b0;
    ack_trap         = 1'b0;
    bus.trap_req_out = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.exc_valid_in || (st_mie && irq_valid)) begin
          state_next = ST_REQ;
          take_trap  = 1'b1;
        end
      end
      ST_REQ: begin
        bus.trap_req_out = 1'b1;
        if (bus.trap_ack_in) begin
          state_next = ST_IDLE;
          ack_trap   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Snapshot cause/epc/tval when a trap is first requested; exceptions win over interrupts
  always_ff @(posedge clock or negedge rst_in) begin
    if (!rst_in) begin
      snap_cause <= '0;
      snap_epc   <= '0;
      snap_tval  <= '0;
    end else if (take_trap) begin
      snap_cause <= bus.exc_valid_in ? {2'b00, bus.exc_cause_in} : {1'b1, irq_code};
      snap_epc   <= bus.pc_in & ~32'h3;
      snap_tval  <= bus.exc_valid_in ? bus.exc_tval_in : 32'h0;
    end
  end

  // mstatus: trap entry beats MRET, which beats a software write
  always_ff @(posedge clock or negedge rst_in) begin
    if (!rst_in) begin
      st_mie  <= 1'b0;
      st_mpie <= 1'b0;
    end else if (ack_trap) begin
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (mret_ok) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (bus.wr_en_in && bus.csr_addr_in == CSR_MSTATUS) begin
      st_mie  <= wdata[3];
      st_mpie <= wdata[7];
    end
  end

  // Remaining CSRs; trap entry owns mepc/mcause/mtval on the acknowledge edge
  always_ff @(posedge clock or negedge rst_in) begin
    if (!rst_in) begin
      mie_q      <= '0;
      mtvec_q    <= RESET_MTVEC;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      if (bus.wr_en_in && bus.csr_addr_in == CSR_MIE)      mie_q <= wdata & MIE_MASK;
      if (bus.wr_en_in && bus.csr_addr_in == CSR_MTVEC)
        mtvec_q <= {wdata[31:2], (wdata[1:0] == MTVEC_VECTORED) ? MTVEC_VECTORED : MTVEC_DIRECT};
      if (bus.wr_en_in && bus.csr_addr_in == CSR_MSCRATCH) mscratch_q <= wdata;
      if (ack_trap) begin
        mepc_q   <= snap_epc;
        mcause_q <= {snap_cause[5], 26'b0, snap_cause[4:0]};
        mtval_q  <= snap_tval;
      end else begin
        if (bus.wr_en_in && bus.csr_addr_in == CSR_MEPC)   mepc_q   <= wdata & ~32'h3;
        if (bus.wr_en_in && bus.csr_addr_in == CSR_MCAUSE) mcause_q <= wdata & 32'h8000_001F;
        if (bus.wr_en_in && bus.csr_addr_in == CSR_MTVAL)  mtval_q  <= wdata;
      end
    end
  end

  assign base                 = {mtvec_q[31:2], 2'b00};
  assign bus.trap_address_out = (mtvec_q[1:0] == MTVEC_VECTORED && snap_cause[5])
                                ? base + {25'b0, snap_cause[4:0], 2'b00} : base;
  assign bus.csr_data_out     = rdata;
  assign bus.epc_out          = mepc_q;
  assign bus.mie_out          = st_mie;
  assign bus.irq_pending_out  = irq_valid;

endmodule
